// File: rtl/usb_ep_in_tx_sequencer.sv
// rtl/usb_ep_in_tx_sequencer.sv - IN endpoint packet sequencer over a transactional pop FIFO
// Optional handshake timeout is enabled with macro USB_TX_TIMEOUT_EN.
module usb_ep_in_tx_sequencer #(
  parameter int LEN_WID        = 7,
  parameter int DATA_WID       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                txReq,
  input  logic [LEN_WID-1:0]  maxPktLen,
  input  logic                txAbort,
  output logic                txByteValid,
  output logic [DATA_WID-1:0] txByte,
  input  logic                txByteReady,
  output logic                txEop,
  input  logic                hsAck,
  input  logic                hsNak,
  output logic                txBusy,
  output logic                txDone,
  output logic                txSuccess,
  output logic [LEN_WID-1:0]  pktLen,
  input  logic                fifoDataAvailable,
  input  logic [DATA_WID-1:0] fifoData,
  output logic                fifoPopData,
  output logic                fifoPopTransDone,
  output logic                fifoPopTransSuccess
);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_STREAM, ST_EOP, ST_WAIT_HS, ST_COMMIT, ST_ROLLBACK
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_WID-1:0] len_q, len_d;
  logic [LEN_WID-1:0] pkt_len_q, pkt_len_d;
  logic               to_expired;

`ifdef USB_TX_TIMEOUT_EN
  localparam int TO_WID = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_WID-1:0] to_cnt_q, to_cnt_d;

  // Counter sits at zero outside WAIT_HS, so it is already clear on entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_WAIT_HS) begin
      to_cnt_d = to_cnt_q + TO_WID'(1);
    end
  end

  assign to_expired = (to_cnt_q == TO_WID'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign to_expired     = 1'b0;
`endif

  assign pktLen = pkt_len_q;
  assign txBusy = nRESET && (state_q != ST_IDLE);

  always_comb begin
    state_d             = state_q;
    len_d               = len_q;
    pkt_len_d           = pkt_len_q;
    txByteValid         = 1'b0;
    txByte              = '0;
    txEop               = 1'b0;
    txDone              = 1'b0;
    txSuccess           = 1'b0;
    fifoPopData         = 1'b0;
    fifoPopTransDone    = 1'b0;
    fifoPopTransSuccess = 1'b0;

    case (state_q)
      ST_INIT: begin
        // State register parks here during reset; hold outputs low until release.
        fifoPopTransDone = nRESET;
        state_d          = ST_IDLE;
      end
      ST_IDLE: begin
        if (txReq) begin
          len_d     = maxPktLen;
          pkt_len_d = '0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        txByte      = fifoData;
        txByteValid = fifoDataAvailable && (pkt_len_q < len_q);
        if (txAbort) begin
          state_d = ST_ROLLBACK;
        end else begin
          fifoPopData = txByteValid && txByteReady;
          if (fifoPopData) begin
            pkt_len_d = pkt_len_q + LEN_WID'(1);
          end
          // No valid byte means either the length limit or an empty FIFO.
          if (!txByteValid) begin
            state_d = ST_EOP;
          end
        end
      end
      ST_EOP: begin
        txEop   = 1'b1;
        state_d = txAbort ? ST_ROLLBACK : ST_WAIT_HS;
      end
      ST_WAIT_HS: begin
        if (txAbort || hsNak) begin
          state_d = ST_ROLLBACK;
        end else if (hsAck) begin
          state_d = ST_COMMIT;
        end else if (to_expired) begin
          state_d = ST_ROLLBACK;
        end
      end
      ST_COMMIT: begin
        fifoPopTransDone    = 1'b1;
        fifoPopTransSuccess = 1'b1;
        txDone              = 1'b1;
        txSuccess           = 1'b1;
        state_d             = ST_IDLE;
      end
      ST_ROLLBACK: begin
        fifoPopTransDone = 1'b1;
        txDone           = 1'b1;
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= ST_INIT;
      len_q     <= '0;
      pkt_len_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pkt_len_q <= pkt_len_d;
    end
  end

endmodule

// File: tb/tb_usb_ep_in_tx_sequencer.sv
// tb/tb_usb_ep_in_tx_sequencer.sv - directed bench for usb_ep_in_tx_sequencer with a transactional FIFO model
module tb_usb_ep_in_tx_sequencer;
  localparam int LW = 7;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          nRESET;
  logic          txReq, txAbort, txByteReady, hsAck, hsNak;
  logic [LW-1:0] maxPktLen;
  logic          txByteValid, txEop, txBusy, txDone, txSuccess;
  logic [DW-1:0] txByte;
  logic [LW-1:0] pktLen;
  logic          fifoDataAvailable, fifoPopData, fifoPopTransDone, fifoPopTransSuccess;
  logic [DW-1:0] fifoData;

  always #5 CLK = ~CLK;

  usb_ep_in_tx_sequencer #(.LEN_WID(LW), .DATA_WID(DW), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .nRESET(nRESET), .txReq(txReq), .maxPktLen(maxPktLen), .txAbort(txAbort),
    .txByteValid(txByteValid), .txByte(txByte), .txByteReady(txByteReady), .txEop(txEop),
    .hsAck(hsAck), .hsNak(hsNak), .txBusy(txBusy), .txDone(txDone), .txSuccess(txSuccess),
    .pktLen(pktLen), .fifoDataAvailable(fifoDataAvailable), .fifoData(fifoData),
    .fifoPopData(fifoPopData), .fifoPopTransDone(fifoPopTransDone),
    .fifoPopTransSuccess(fifoPopTransSuccess)
  );

  // Transactional FIFO model: pops advance rd, commit moves base, rollback restores rd.
  logic [DW-1:0] mem [0:63];
  int            fill_n = 0;
  int            rd_q = 0;
  int            base_q = 0;
  logic          fifo_clr = 1'b0;

  assign fifoDataAvailable = (rd_q < fill_n);
  assign fifoData          = mem[rd_q[5:0]];

  always @(posedge CLK) begin
    if (fifo_clr) begin
      rd_q   <= 0;
      base_q <= 0;
    end else if (fifoPopTransDone) begin
      if (fifoPopTransSuccess) base_q <= rd_q;
      else rd_q <= base_q;
    end else if (fifoPopData) begin
      rd_q <= rd_q + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int bad_pop = 0;
  int overlap = 0;
  logic [DW-1:0] got[$];
  logic s_valid, s_pop, s_eop, s_done, s_succ, s_ptd, s_pts, s_busy;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle 1ns after the falling edge, then advance to the next falling edge.
  task automatic cyc();
    #1;
    s_valid = txByteValid; s_pop = fifoPopData; s_eop = txEop; s_busy = txBusy;
    s_done = txDone; s_succ = txSuccess; s_ptd = fifoPopTransDone; s_pts = fifoPopTransSuccess;
    if (fifoPopData) begin
      got.push_back(txByte);
      if (!txByteReady) bad_pop++;
      if (fifoPopTransDone) overlap++;
    end
    @(negedge CLK);
  endtask

  task automatic load_fifo(input int n, input int first);
    fifo_clr = 1'b1;
    cyc();
    fifo_clr = 1'b0;
    for (int i = 0; i < n; i++) mem[i] = 8'(first + i);
    fill_n = n;
  endtask

  task automatic start_pkt(input int max_len);
    got.delete();
    txReq = 1'b1;
    maxPktLen = LW'(max_len);
    cyc();
    txReq = 1'b0;
  endtask

  task automatic run_to_eop(input bit toggle, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      txByteReady = toggle ? ((i % 2) == 0) : 1'b1;
      cyc();
      if (s_eop) break;
      n++;
    end
    txByteReady = 1'b1;
    if (!s_eop) check_eq("eop_wait_expired", 0, 1);
  endtask

  task automatic handshake(input bit ack, input bit nak);
    hsAck = ack;
    hsNak = nak;
    cyc();
    hsAck = 1'b0;
    hsNak = 1'b0;
    cyc();
  endtask

  int n;

  initial begin
    nRESET = 1'b0; txReq = 1'b0; txAbort = 1'b0; txByteReady = 1'b1;
    hsAck = 1'b0; hsNak = 1'b0; maxPktLen = '0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check_eq("rst_busy", txBusy, 0);
    check_eq("rst_ptd", fifoPopTransDone, 0);
    check_eq("rst_pktlen", pktLen, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    cyc();
    check_eq("init_ptd", s_ptd, 1);
    check_eq("init_pts", s_pts, 0);
    check_eq("init_done", s_done, 0);
    cyc();
    check_eq("idle_busy", s_busy, 0);

    // Short packet: 5 bytes against a limit of 8
    load_fifo(5, 'h11);
    start_pkt(8);
    run_to_eop(1'b0, n);
    check_eq("t1_stream_cycles", n, 6);
    check_eq("t1_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) check_eq($sformatf("t1_byte%0d", i), got[i], 'h11 + i);
    check_eq("t1_pktlen", pktLen, 5);
    handshake(1'b1, 1'b0);
    check_eq("t1_done", s_done, 1);
    check_eq("t1_succ", s_succ, 1);
    check_eq("t1_ptd", s_ptd, 1);
    check_eq("t1_pts", s_pts, 1);
    check_eq("t1_fifo_rd", rd_q, 5);

    // Limit-bounded packet with backpressure, NAK, then resend
    load_fifo(20, 'h40);
    start_pkt(8);
    run_to_eop(1'b1, n);
    check_eq("t2_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check_eq($sformatf("t2_byte%0d", i), got[i], 'h40 + i);
    check_eq("t2_pktlen", pktLen, 8);
    handshake(1'b0, 1'b1);
    check_eq("t2_done", s_done, 1);
    check_eq("t2_succ", s_succ, 0);
    check_eq("t2_pts", s_pts, 0);
    check_eq("t2_fifo_rd", rd_q, 0);
    start_pkt(8);
    run_to_eop(1'b0, n);
    check_eq("t2r_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check_eq($sformatf("t2r_byte%0d", i), got[i], 'h40 + i);
    handshake(1'b1, 1'b0);
    check_eq("t2r_succ", s_succ, 1);
    check_eq("t2r_fifo_rd", rd_q, 8);

    // Zero-length packet from an empty FIFO
    load_fifo(0, 0);
    start_pkt(8);
    run_to_eop(1'b0, n);
    check_eq("t3_stream_cycles", n, 1);
    check_eq("t3_count", got.size(), 0);
    check_eq("t3_pktlen", pktLen, 0);
    handshake(1'b1, 1'b0);
    check_eq("t3_succ", s_succ, 1);

    // Abort after 3 bytes, then ACK+NAK collision
    load_fifo(6, 'h60);
    start_pkt(8);
    cyc(); cyc(); cyc();
    txAbort = 1'b1;
    cyc();
    check_eq("t4_abort_pop", s_pop, 0);
    txAbort = 1'b0;
    cyc();
    check_eq("t4_done", s_done, 1);
    check_eq("t4_succ", s_succ, 0);
    check_eq("t4_count", got.size(), 3);
    check_eq("t4_pktlen", pktLen, 3);
    check_eq("t4_fifo_rd", rd_q, 0);
    start_pkt(8);
    run_to_eop(1'b0, n);
    check_eq("t4b_count", got.size(), 6);
    handshake(1'b1, 1'b1);
    check_eq("t4b_done", s_done, 1);
    check_eq("t4b_succ", s_succ, 0);
    check_eq("t4b_fifo_rd", rd_q, 0);

    // Reset mid-stream
    start_pkt(8);
    cyc(); cyc();
    nRESET = 1'b0;
    #1;
    check_eq("t5_rst_valid", txByteValid, 0);
    check_eq("t5_rst_pop", fifoPopData, 0);
    check_eq("t5_rst_byte", txByte, 0);
    check_eq("t5_rst_pktlen", pktLen, 0);
    check_eq("t5_rst_busy", txBusy, 0);
    check_eq("t5_rst_ptd", fifoPopTransDone, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    cyc();
    check_eq("t5_init_ptd", s_ptd, 1);
    check_eq("t5_init_pts", s_pts, 0);
    cyc();
    check_eq("t5_idle_busy", s_busy, 0);
    check_eq("t5_fifo_rd", rd_q, 0);

`ifdef USB_TX_TIMEOUT_EN
    // Timeout of 16 WAIT_HS cycles, and an ACK on the 16th cycle
    load_fifo(0, 0);
    start_pkt(4);
    run_to_eop(1'b0, n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n++;
      if (s_done) break;
    end
    check_eq("t6_timeout_cycle", n, 17);
    check_eq("t6_timeout_succ", s_succ, 0);
    start_pkt(4);
    run_to_eop(1'b0, n);
    for (int i = 0; i < 15; i++) cyc();
    handshake(1'b1, 1'b0);
    check_eq("t6_ack_done", s_done, 1);
    check_eq("t6_ack_succ", s_succ, 1);
`endif

    check_eq("bad_pop_without_ready", bad_pop, 0);
    check_eq("pop_with_transdone", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
